// File: rtl/spi_cmd_pkg.sv
// Shared op codes, FSM state type and limits for the SPI command master.
package spi_cmd_pkg;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_FAST = 2'b11;

  localparam int unsigned MIN_CLK_DIV = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    WFETCH,
    DATA,
    HOLD,
    GAP
  } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI bit-timing generator: CLK_DIV cycles low then CLK_DIV cycles high per bit,
// free-running while en is high and parked at the start of a low phase otherwise.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick,
  output logic sample_tick
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             high_q, high_d;
  logic             last;

  assign last = (cnt_q == CNT_W'(CLK_DIV - 1));

  always_comb begin
    cnt_d  = cnt_q;
    high_d = high_q;
    if (!en) begin
      cnt_d  = '0;
      high_d = 1'b0;
    end else if (last) begin
      cnt_d  = '0;
      high_d = ~high_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q  <= '0;
      high_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      high_q <= high_d;
    end
  end

  assign rise_tick   = en && last && !high_q;
  assign sample_tick = en && last && high_q;
  // sclk drops on the same clk edge that captures miso
  assign fall_tick   = sample_tick;

endmodule

// File: rtl/spi_cmd_master.sv
// SPI initiator (CPOL=0) for the register slave: command byte, then data words, MSB first.
// Define SPI_CMD_MASTER_BURST_EN to honour cmd_len; otherwise every frame carries one word.
module spi_cmd_master
  import spi_cmd_pkg::*;
#(
  parameter int unsigned REG_W   = 8,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned LEN_W   = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [5:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [REG_W-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [REG_W-1:0] rd_data,
  output logic             rd_vld,
  output logic [7:0]       status,
  output logic             status_vld,
  output logic             busy,
  output logic             sclk,
  output logic             mosi,
  output logic             nss,
  input  logic             miso
);

  // The slave's 3-stage synchronizer cannot follow anything faster.
  localparam int unsigned DIV    = (CLK_DIV < MIN_CLK_DIV) ? MIN_CLK_DIV : CLK_DIV;
  localparam int unsigned BIT_W  = $clog2(REG_W);
  localparam int unsigned WAIT_W = $clog2(2 * DIV);

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [REG_W-1:0]   tx_q, tx_d;
  logic [REG_W-2:0]   rx_q, rx_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WAIT_W-1:0]  wcnt_q, wcnt_d;
  logic               sclk_q, sclk_d;
  logic [REG_W-1:0]   rd_data_q, rd_data_d;
  logic               rd_vld_q, rd_vld_d;
  logic [7:0]         status_q, status_d;
  logic               status_vld_q, status_vld_d;
  logic               shift_en, rise_tick, fall_tick, sample_tick;
  logic               rd_like;
`ifdef SPI_CMD_MASTER_BURST_EN
  logic [LEN_W-1:0]   len_q, len_d;
`else
  logic               unused_len;
  assign unused_len = ^cmd_len;
`endif

  assign shift_en = (state_q == CMD) || (state_q == DATA);
  // Ops 00 and 01 both return data words to the requester.
  assign rd_like  = ((op_q & OP_WR) == OP_RD);

  spi_sclk_gen #(
    .CLK_DIV(DIV)
  ) u_sclk_gen (
    .clk        (clk),
    .nrst       (nrst),
    .en         (shift_en),
    .rise_tick  (rise_tick),
    .fall_tick  (fall_tick),
    .sample_tick(sample_tick)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    bit_d        = bit_q;
    wcnt_d       = '0;
    rd_data_d    = rd_data_q;
    rd_vld_d     = 1'b0;
    status_d     = status_q;
    status_vld_d = 1'b0;
    sclk_d       = sclk_q;
`ifdef SPI_CMD_MASTER_BURST_EN
    len_d        = len_q;
`endif
    if (rise_tick) sclk_d = 1'b1;
    if (fall_tick) sclk_d = 1'b0;

    if (shift_en && sample_tick) begin
      tx_d  = {tx_q[REG_W-2:0], 1'b0};
      rx_d  = {rx_q[REG_W-3:0], miso};
      bit_d = bit_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          tx_d    = REG_W'({cmd_op, cmd_addr}) << (REG_W - 8);
`ifdef SPI_CMD_MASTER_BURST_EN
          len_d   = cmd_len;
`endif
          state_d = SETUP;
        end
      end
      SETUP: begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == WAIT_W'(DIV - 1)) begin
          wcnt_d  = '0;
          bit_d   = BIT_W'(7);
          state_d = CMD;
        end
      end
      CMD: begin
        if (sample_tick && (bit_q == '0)) begin
          status_d     = {rx_q[6:0], miso};
          status_vld_d = 1'b1;
          bit_d        = BIT_W'(REG_W - 1);
          case (op_q)
            OP_FAST: state_d = HOLD;
            OP_WR:   state_d = WFETCH;
            default: state_d = DATA;
          endcase
        end
      end
      WFETCH: begin
        if (wr_valid) begin
          tx_d    = wr_data;
          state_d = DATA;
        end
      end
      DATA: begin
        if (sample_tick && (bit_q == '0)) begin
          bit_d = BIT_W'(REG_W - 1);
          if (rd_like) begin
            rd_data_d = {rx_q, miso};
            rd_vld_d  = 1'b1;
          end
`ifdef SPI_CMD_MASTER_BURST_EN
          if (len_q == '0) begin
            state_d = HOLD;
          end else begin
            len_d   = len_q - 1'b1;
            state_d = rd_like ? DATA : WFETCH;
          end
`else
          state_d = HOLD;
`endif
        end
      end
      HOLD: begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == WAIT_W'(DIV - 1)) begin
          wcnt_d  = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == WAIT_W'(2 * DIV - 1)) begin
          wcnt_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      op_q         <= OP_RD;
      tx_q         <= '0;
      rx_q         <= '0;
      bit_q        <= '0;
      wcnt_q       <= '0;
      sclk_q       <= 1'b0;
      rd_data_q    <= '0;
      rd_vld_q     <= 1'b0;
      status_q     <= '0;
      status_vld_q <= 1'b0;
`ifdef SPI_CMD_MASTER_BURST_EN
      len_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      bit_q        <= bit_d;
      wcnt_q       <= wcnt_d;
      sclk_q       <= sclk_d;
      rd_data_q    <= rd_data_d;
      rd_vld_q     <= rd_vld_d;
      status_q     <= status_d;
      status_vld_q <= status_vld_d;
`ifdef SPI_CMD_MASTER_BURST_EN
      len_q        <= len_d;
`endif
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = ~cmd_ready;
  assign nss        = (state_q == IDLE) || (state_q == GAP);
  assign mosi       = ~nss & tx_q[REG_W-1];
  assign sclk       = sclk_q;
  assign wr_ready   = (state_q == WFETCH) && wr_valid;
  assign rd_data    = rd_data_q;
  assign rd_vld     = rd_vld_q;
  assign status     = status_q;
  assign status_vld = status_vld_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Scoreboard bench for spi_cmd_master against a behavioural register slave.
module tb_spi_cmd_master;
  import spi_cmd_pkg::*;

  localparam int REG_W   = 8;
  localparam int CLK_DIV = 4;
  localparam int LEN_W   = 4;
`ifdef SPI_CMD_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             nrst;
  logic             cmd_valid, cmd_ready;
  logic [1:0]       cmd_op;
  logic [5:0]       cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [REG_W-1:0] wr_data;
  logic             wr_valid, wr_ready;
  logic [REG_W-1:0] rd_data;
  logic             rd_vld;
  logic [7:0]       status;
  logic             status_vld, busy, sclk, mosi, nss;
  logic             miso = 1'b0;

  spi_cmd_master #(
    .REG_W  (REG_W),
    .CLK_DIV(CLK_DIV),
    .LEN_W  (LEN_W)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_vld    (rd_vld),
    .status    (status),
    .status_vld(status_vld),
    .busy      (busy),
    .sclk      (sclk),
    .mosi      (mosi),
    .nss       (nss),
    .miso      (miso)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_min(input string name, input int act, input int lim);
    tests++;
    if (act < lim) begin
      fails++;
      $display("FAIL %s: got %0d, expected at least %0d", name, act, lim);
    end
  endtask

  task automatic chk_max(input string name, input int act, input int lim);
    tests++;
    if (act > lim) begin
      fails++;
      $display("FAIL %s: got %0d, expected at most %0d", name, act, lim);
    end
  endtask

  // Scoreboard queues, filled by the stimulus
  logic [7:0] exp_status[$];
  logic [7:0] exp_rd[$];
  logic [7:0] exp_mosi[$];
  logic [7:0] wr_words[$];
  int         wr_delay[$];

  // Per-frame observations
  int cyc = 0, frame_edges = 0, nss_rises = 0, rdv_cnt = 0, stv_cnt = 0, wrr_cnt = 0;
  int low_run = 0, max_low = 0, rise_cyc = 0, done_cyc = 0;
  logic nss_prev = 1'b1;

  always @(posedge clk) cyc++;

  // Output monitor: pops expectations whenever the DUT presents a pulse
  always @(negedge clk) begin
    if (status_vld) begin
      stv_cnt++;
      if (exp_status.size() == 0) begin
        tests++; fails++;
        $display("FAIL status_unexpected: got 0x%0h, expected no pulse", status);
      end else chk("status", 32'(status), 32'(exp_status.pop_front()));
    end
    if (rd_vld) begin
      rdv_cnt++;
      if (exp_rd.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_unexpected: got 0x%0h, expected no pulse", rd_data);
      end else chk("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
    end
    if (wr_ready) wrr_cnt++;
    if (nss && !nss_prev) begin
      nss_rises++;
      rise_cyc = cyc;
    end
    nss_prev = nss;
    if (busy && !nss && !sclk) low_run++;
    else low_run = 0;
    if (low_run > max_low) max_low = low_run;
  end

  // Behavioural slave: status byte first, then register reads with auto-increment
  logic [7:0] regs [64];
  logic [7:0] slave_status = 8'h00;
  logic [7:0] s_rx = 8'h00, s_tx = 8'h00, s_cmd = 8'h00;
  logic [5:0] s_addr = 6'h00;
  int         sbit = 0;

  always @(negedge nss) begin
    sbit = 0;
    s_tx = slave_status;
    miso = s_tx[7];
  end

  always @(posedge sclk) begin
    if (!nss) begin
      s_rx = {s_rx[6:0], mosi};
      sbit++;
      frame_edges++;
      if (sbit % 8 == 0) begin
        if (sbit == 8) begin
          s_cmd  = s_rx;
          s_addr = s_rx[5:0];
        end
        if (exp_mosi.size() == 0) begin
          tests++; fails++;
          $display("FAIL mosi_unexpected: got 0x%0h, expected no byte", s_rx);
        end else chk("mosi_byte", 32'(s_rx), 32'(exp_mosi.pop_front()));
      end
    end
  end

  always @(negedge sclk) begin
    if (!nss) begin
      if (sbit % 8 == 0) begin
        if (s_cmd[7:6] == 2'b00) begin
          s_tx   = regs[s_addr];
          s_addr = s_addr + 6'd1;
        end else s_tx = 8'h00;
      end else s_tx = {s_tx[6:0], 1'b0};
      miso = s_tx[7];
    end
  end

  // Write-data driver: each word is withheld for its delay (in cycles) once eligible
  int wr_wait = 0;
  initial begin : wr_drv
    wr_valid = 1'b0;
    wr_data  = '0;
    forever begin
      @(negedge clk);
      if (wr_valid && wr_ready) begin
        @(posedge clk);
        #1 wr_valid = 1'b0;
      end else if (!wr_valid && wr_words.size() > 0) begin
        if (wr_wait < wr_delay[0]) wr_wait++;
        else begin
          wr_data = wr_words.pop_front();
          void'(wr_delay.pop_front());
          wr_valid = 1'b1;
          wr_wait  = 0;
        end
      end
    end
  end

  task automatic start_frame();
    frame_edges = 0; nss_rises = 0; rdv_cnt = 0; stv_cnt = 0; wrr_cnt = 0; max_low = 0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] addr, input logic [LEN_W-1:0] len);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      tests++; fails++;
      $display("FAIL issue_timeout: cmd_ready=%0b, expected 1", cmd_ready);
    end
    cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    done_cyc = cyc;
    if (n >= 3000) begin
      tests++; fails++;
      $display("FAIL %s_timeout: cmd_ready=%0b, expected 1", name, cmd_ready);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int nw;
    for (int i = 0; i < 64; i++) regs[i] = 8'h00;
    nrst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 6'h00; cmd_len = '0;

    #22;
    chk("rst_nss", 32'(nss), 1);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pulses", {29'd0, wr_ready, rd_vld, status_vld}, 0);
    chk("rst_data", {16'd0, rd_data, status}, 0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);

    // Single read
    regs[5] = 8'hA7; slave_status = 8'h3C;
    start_frame();
    exp_mosi.push_back(8'h05); exp_mosi.push_back(8'h00);
    exp_status.push_back(8'h3C); exp_rd.push_back(8'hA7);
    issue(OP_RD, 6'h05, '0);
    wait_done("rd");
    chk("rd_edges", 32'(frame_edges), 16);
    chk("rd_nss_rises", 32'(nss_rises), 1);
    chk("rd_status_pulses", 32'(stv_cnt), 1);
    chk("rd_rd_pulses", 32'(rdv_cnt), 1);
    chk_max("rd_max_low_run", max_low, 2 * CLK_DIV);

    // Single write
    slave_status = 8'h81;
    start_frame();
    exp_mosi.push_back(8'h82); exp_mosi.push_back(8'h5A); exp_status.push_back(8'h81);
    wr_words.push_back(8'h5A); wr_delay.push_back(0);
    issue(OP_WR, 6'h02, '0);
    wait_done("wr");
    chk("wr_edges", 32'(frame_edges), 16);
    chk("wr_ready_pulses", 32'(wrr_cnt), 1);
    chk("wr_rd_pulses", 32'(rdv_cnt), 0);
    chk("wr_nss_rises", 32'(nss_rises), 1);

    // Fastcmd; len must be ignored
    slave_status = 8'h42;
    start_frame();
    exp_mosi.push_back(8'hD5); exp_status.push_back(8'h42);
    issue(OP_FAST, 6'h15, 4'd3);
    wait_done("fast");
    chk("fast_edges", 32'(frame_edges), 8);
    chk_min("fast_nss_gap", done_cyc - rise_cyc, 2 * CLK_DIV);
    chk("fast_cmd_ready", 32'(cmd_ready), 1);
    chk("fast_nss_rises", 32'(nss_rises), 1);

    // Reserved op 01: still reports a (zero) word
    slave_status = 8'h5E; regs[1] = 8'hEE;
    start_frame();
    exp_mosi.push_back(8'h41); exp_mosi.push_back(8'h00);
    exp_status.push_back(8'h5E); exp_rd.push_back(8'h00);
    issue(2'b01, 6'h01, '0);
    wait_done("op01");
    chk("op01_rd_pulses", 32'(rdv_cnt), 1);

    // Burst read, len=2
    regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; slave_status = 8'hC3;
    nw = BURST ? 3 : 1;
    start_frame();
    exp_mosi.push_back(8'h00); exp_status.push_back(8'hC3);
    for (int i = 0; i < nw; i++) begin
      exp_mosi.push_back(8'h00);
      exp_rd.push_back(regs[i]);
    end
    issue(OP_RD, 6'h00, 4'd2);
    wait_done("brd");
    chk("brd_edges", 32'(frame_edges), 32'(8 + 8 * nw));
    chk("brd_rd_pulses", 32'(rdv_cnt), 32'(nw));
    chk("brd_nss_rises", 32'(nss_rises), 1);

    // Burst write with a stalled word; without bursts the single word is stalled instead
    slave_status = 8'h18;
    nw = BURST ? 2 : 1;
    start_frame();
    exp_mosi.push_back(8'h83); exp_mosi.push_back(8'hA1); exp_status.push_back(8'h18);
    if (BURST) begin
      exp_mosi.push_back(8'hB2);
      wr_words.push_back(8'hA1); wr_delay.push_back(0);
      wr_words.push_back(8'hB2); wr_delay.push_back(84);
    end else begin
      wr_words.push_back(8'hA1); wr_delay.push_back(90);
    end
    issue(OP_WR, 6'h03, 4'd1);
    wait_done("bwr");
    chk("bwr_edges", 32'(frame_edges), 32'(8 + 8 * nw));
    chk("bwr_ready_pulses", 32'(wrr_cnt), 32'(nw));
    chk("bwr_nss_rises", 32'(nss_rises), 1);
    chk_min("bwr_stall_low_run", max_low, 15);
    chk("bwr_words_left", 32'(wr_words.size()), 0);

    // Reset during bit 3 of the command byte
    regs[7] = 8'h99; slave_status = 8'h66;
    start_frame();
    issue(OP_RD, 6'h07, '0);
    begin
      int n = 0;
      while (frame_edges < 5 && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (n >= 500) begin
        tests++; fails++;
        $display("FAIL rstmid_wait: got %0d edges, expected 5", frame_edges);
      end
    end
    #3 nrst = 1'b0;
    #1;
    chk("rstmid_nss", 32'(nss), 1);
    chk("rstmid_sclk", 32'(sclk), 0);
    chk("rstmid_cmd_ready", 32'(cmd_ready), 1);
    chk("rstmid_mosi", 32'(mosi), 0);
    chk("rstmid_status", 32'(status), 0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (40) @(negedge clk);
    chk("rstmid_status_pulses", 32'(stv_cnt), 0);
    chk("rstmid_rd_pulses", 32'(rdv_cnt), 0);
    chk("rstmid_edges", 32'(frame_edges), 5);
    chk("rstmid_idle", 32'(cmd_ready), 1);

    chk("left_status", 32'(exp_status.size()), 0);
    chk("left_rd", 32'(exp_rd.size()), 0);
    chk("left_mosi", 32'(exp_mosi.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
